// File: rtl/ect_pkg.sv
// Shared types and constants for the demodulator-to-USB packer.
package ect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_WR   = 2'd2,
        ST_TRL  = 2'd3
    } state_e;

    localparam logic [31:0] TRAILER_DEF = 32'hFAFA_E0E0;
    localparam int          WORD_W      = 32;

    // Two samples share one 32-bit word; an odd channel count pads the last word.
    function automatic int num_words(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/sample_conv.sv
// Converts one signed IN_W result to an OUT_W sample.
// ROUND_SAT_EN selects round-half-up with saturation; otherwise plain truncation.
module sample_conv #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);
    localparam int S = IN_W - OUT_W;

    if (S == 0) begin : g_pass
        assign out_o = in_i;
    end else begin : g_conv
`ifdef ROUND_SAT_EN
        localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (S - 1);

        logic signed [IN_W:0]  sum_s;
        logic signed [IN_W:0]  shr_full_s;
        logic        [OUT_W:0] shr_s;

        // Round with one guard bit, then clamp when the kept sign bits disagree.
        always_comb begin
            sum_s      = $signed({in_i[IN_W-1], in_i}) + $signed(HALF);
            shr_full_s = sum_s >>> S;
            shr_s      = shr_full_s[OUT_W:0];
            if (shr_s[OUT_W] != shr_s[OUT_W-1]) begin
                out_o = shr_s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                out_o = shr_s[OUT_W-1:0];
            end
        end
`else
        logic unused_s;
        assign unused_s = ^in_i[S-1:0];
        assign out_o    = in_i[IN_W-1 -: OUT_W];
`endif
    end

endmodule

// File: rtl/demod_usb_packer.sv
// Captures NUM_CH demodulator results, packs two 16-bit samples per word into the USB FIFO,
// and appends a trailer on FrameEnd. Sample conversion mode follows ROUND_SAT_EN.
module demod_usb_packer
    import ect_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          IN_W      = 32,
    parameter int          OUT_W     = 16,
    parameter int          FIFO_AW   = 12,
    parameter int          AFULL_LVL = 4090,
    parameter logic [31:0] TRAILER   = TRAILER_DEF
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   DemodReady,
    input  logic [NUM_CH*IN_W-1:0] DemodData,
    input  logic                   FrameEnd,
    input  logic                   USBFull,
    input  logic [FIFO_AW-1:0]     NumFIFO,
    output logic                   USBWRreq,
    output logic [WORD_W-1:0]      USBWrite,
    output logic                   Busy,
    output logic                   Overflow,
    output logic [15:0]            DropCnt
);
    localparam int NW    = num_words(NUM_CH);
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    state_e                 state_q;
    logic [NUM_CH*IN_W-1:0] data_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   trl_pend_q;
    logic                   fe_q;

    logic [OUT_W-1:0]  samp_s [NUM_CH];
    logic [WORD_W-1:0] word_s [NW];
    logic              wr_ok_s;
    logic              fe_rise_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sample_conv #(.IN_W(IN_W), .OUT_W(OUT_W)) u_conv (
            .in_i  (data_q[k*IN_W +: IN_W]),
            .out_o (samp_s[k])
        );
    end

    for (genvar j = 0; j < NW; j++) begin : g_word
        if (2*j + 1 < NUM_CH) begin : g_pair
            assign word_s[j] = {samp_s[2*j], samp_s[2*j+1]};
        end else begin : g_pad
            assign word_s[j] = {samp_s[2*j], {OUT_W{1'b0}}};
        end
    end

    assign wr_ok_s   = !USBFull && (NumFIFO < FIFO_AW'(AFULL_LVL));
    assign fe_rise_s = FrameEnd && !fe_q;

    // Packer FSM: CONV already issues word 0 so the first strobe lands two cycles after capture.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            idx_q      <= '0;
            trl_pend_q <= 1'b0;
            fe_q       <= 1'b0;
            USBWRreq   <= 1'b0;
            USBWrite   <= 32'h0000_0000;
            Busy       <= 1'b0;
            Overflow   <= 1'b0;
            DropCnt    <= 16'h0000;
        end else begin
            USBWRreq <= 1'b0;
            fe_q     <= FrameEnd;
            if (DemodReady && (state_q != ST_IDLE)) begin
                Overflow <= 1'b1;
                if (DropCnt != 16'hFFFF) begin
                    DropCnt <= DropCnt + 16'h0001;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (DemodReady) begin
                        data_q  <= DemodData;
                        idx_q   <= '0;
                        Busy    <= 1'b1;
                        state_q <= ST_CONV;
                    end else if (trl_pend_q) begin
                        state_q <= ST_TRL;
                    end
                end
                ST_CONV, ST_WR: begin
                    if (wr_ok_s) begin
                        USBWRreq <= 1'b1;
                        USBWrite <= word_s[idx_q];
                        if (idx_q == LAST_IDX) begin
                            if (trl_pend_q) begin
                                state_q <= ST_TRL;
                            end else begin
                                Busy    <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_WR;
                        end
                    end else begin
                        state_q <= ST_WR;
                    end
                end
                ST_TRL: begin
                    if (wr_ok_s) begin
                        USBWRreq   <= 1'b1;
                        USBWrite   <= TRAILER;
                        trl_pend_q <= 1'b0;
                        Busy       <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // A fresh edge wins over the clear so it is never lost.
            if (fe_rise_s) begin
                trl_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demod_usb_packer.sv
// Directed bench for demod_usb_packer: 4-channel and 3-channel instances, hand-computed words.
module tb_demod_usb_packer;
    import ect_pkg::*;

`ifdef ROUND_SAT_EN
    localparam logic [31:0] EXP_W0 = 32'h1235_7FFF;
`else
    localparam logic [31:0] EXP_W0 = 32'h1234_7FFF;
`endif
    localparam logic [31:0] EXP_W1  = 32'h8000_FFFF;
    localparam logic [31:0] EXP3_W1 = 32'h0001_0000;
    localparam logic [31:0] EXP_TRL = 32'hFAFA_E0E0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         dr4 = 1'b0;
    logic         dr3 = 1'b0;
    logic [127:0] data4;
    logic [95:0]  data3;
    logic         frame_end = 1'b0;
    logic         usb_full = 1'b0;
    logic [11:0]  num_fifo = 12'd0;

    logic         wrreq4, busy4, ovf4;
    logic [31:0]  wdata4;
    logic [15:0]  drop4;
    logic         wrreq3, busy3, ovf3;
    logic [31:0]  wdata3;
    logic [15:0]  drop3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int c0;

    logic [31:0] q4_data[$];
    int          q4_cyc[$];
    logic [31:0] q3_data[$];
    bit          busy_h[int];

    assign data4 = {32'hFFFF_7FFF, 32'h8000_0000, 32'h7FFF_8000, 32'h1234_8000};
    assign data3 = {32'h0001_0000, 32'h7FFF_8000, 32'h1234_8000};

    demod_usb_packer #(.NUM_CH(4)) dut4 (
        .Clk(clk), .Rst(rst_n), .DemodReady(dr4), .DemodData(data4),
        .FrameEnd(frame_end), .USBFull(usb_full), .NumFIFO(num_fifo),
        .USBWRreq(wrreq4), .USBWrite(wdata4), .Busy(busy4),
        .Overflow(ovf4), .DropCnt(drop4)
    );

    demod_usb_packer #(.NUM_CH(3)) dut3 (
        .Clk(clk), .Rst(rst_n), .DemodReady(dr3), .DemodData(data3),
        .FrameEnd(frame_end), .USBFull(usb_full), .NumFIFO(num_fifo),
        .USBWRreq(wrreq3), .USBWrite(wdata3), .Busy(busy3),
        .Overflow(ovf3), .DropCnt(drop3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every FIFO write and the Busy level mid-cycle.
    always @(negedge clk) begin
        busy_h[cyc] = busy4;
        if (wrreq4) begin
            q4_data.push_back(wdata4);
            q4_cyc.push_back(cyc);
        end
        if (wrreq3) begin
            q3_data.push_back(wdata3);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q4_data.delete();
        q4_cyc.delete();
        q3_data.delete();
    endtask

    function automatic logic [31:0] qd4(input int i);
        return (i < q4_data.size()) ? q4_data[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] qc4(input int i);
        return (i < q4_cyc.size()) ? 32'(q4_cyc[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qd3(input int i);
        return (i < q3_data.size()) ? q3_data[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic pulse4();
        dr4 = 1'b1;
        c0  = cyc;
        tick(1);
        dr4 = 1'b0;
    endtask

    initial begin
        tick(3);
        check_val("rst_wrreq",  32'(wrreq4), 32'd0);
        check_val("rst_wdata",  wdata4, 32'h0000_0000);
        check_val("rst_busy",   32'(busy4), 32'd0);
        check_val("rst_ovf",    32'(ovf4), 32'd0);
        check_val("rst_drop",   32'(drop4), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic burst on both instances.
        clear_q();
        dr3 = 1'b1;
        pulse4();
        dr3 = 1'b0;
        tick(6);
        check_val("b_count",  32'(q4_data.size()), 32'd2);
        check_val("b_w0",     qd4(0), EXP_W0);
        check_val("b_w1",     qd4(1), EXP_W1);
        check_val("b_cyc0",   qc4(0), 32'(c0 + 2));
        check_val("b_cyc1",   qc4(1), 32'(c0 + 3));
        check_val("b_busy",   32'(busy4), 32'd0);
        check_val("b_ovf",    32'(ovf4), 32'd0);
        check_val("b3_count", 32'(q3_data.size()), 32'd2);
        check_val("b3_w0",    qd3(0), EXP_W0);
        check_val("b3_w1",    qd3(1), EXP3_W1);

        // USBFull held for five cycles after word 0.
        clear_q();
        pulse4();
        tick(1);
        usb_full = 1'b1;
        tick(5);
        usb_full = 1'b0;
        tick(5);
        check_val("f_count", 32'(q4_data.size()), 32'd2);
        check_val("f_w0",    qd4(0), EXP_W0);
        check_val("f_w1",    qd4(1), EXP_W1);
        check_val("f_cyc0",  qc4(0), 32'(c0 + 2));
        check_val("f_cyc1",  qc4(1), 32'(c0 + 8));

        // Almost-full threshold: 4090 stalls, 4089 writes.
        clear_q();
        num_fifo = 12'd4090;
        pulse4();
        tick(2);
        num_fifo = 12'd4089;
        tick(5);
        num_fifo = 12'd0;
        check_val("a_count", 32'(q4_data.size()), 32'd2);
        check_val("a_cyc0",  qc4(0), 32'(c0 + 4));
        check_val("a_cyc1",  qc4(1), 32'(c0 + 5));
        check_val("a_w1",    qd4(1), EXP_W1);

        // FrameEnd with DemodReady, plus a merged second edge mid-burst.
        clear_q();
        frame_end = 1'b1;
        pulse4();
        frame_end = 1'b0;
        tick(1);
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        tick(8);
        check_val("t_count", 32'(q4_data.size()), 32'd3);
        check_val("t_w0",    qd4(0), EXP_W0);
        check_val("t_w1",    qd4(1), EXP_W1);
        check_val("t_trl",   qd4(2), EXP_TRL);
        check_val("t_cyc2",  qc4(2), 32'(c0 + 4));
        check_val("t_busy3", 32'(busy_h[c0 + 3]), 32'd1);
        check_val("t_busy4", 32'(busy_h[c0 + 4]), 32'd0);

        // FrameEnd alone while idle.
        clear_q();
        frame_end = 1'b1;
        c0 = cyc;
        tick(2);
        frame_end = 1'b0;
        tick(5);
        check_val("i_count", 32'(q4_data.size()), 32'd1);
        check_val("i_trl",   qd4(0), EXP_TRL);
        check_val("i_cyc",   qc4(0), 32'(c0 + 3));

        // Second DemodReady during the burst is dropped.
        clear_q();
        pulse4();
        tick(1);
        dr4 = 1'b1;
        tick(1);
        dr4 = 1'b0;
        tick(6);
        check_val("d_count", 32'(q4_data.size()), 32'd2);
        check_val("d_w0",    qd4(0), EXP_W0);
        check_val("d_w1",    qd4(1), EXP_W1);
        check_val("d_drop",  32'(drop4), 32'd1);
        check_val("d_ovf",   32'(ovf4), 32'd1);
        check_val("d_busy",  32'(busy4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
